wb_commit_stage: RTL and testbench

// - Final (write-back/commit) pipeline stage; consumes MEM's registered wb_ctrl_bus, wb_csr_bus and mem_excp_bus.
// - Retires instructions: register file writes, CSR writes and LLbit updates.
// - Turns a committing exception or ertn into the global excp_flush/ertn_flush.
// - Keeps a retired-instruction counter and a sticky break halt.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_commit_trace.sv | 42 ++++
 rtl/wb_commit_stage.sv | 142 ++++++++++++++
 tb/tb_wb_commit_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Field layout of the MEM->WB buses and the write-back stage state encoding.
// Offsets are the single source of truth for slicing wb_ctrl_bus, wb_csr_bus and mem_excp_bus.
package wb_pkg;

    localparam int WB_CTRL_W       = 361;
    localparam int WB_RESULT_LSB   = 0;
    localparam int WB_PC_LSB       = 32;
    localparam int WB_INST_LSB     = 64;
    localparam int WB_WEN_BIT      = 96;
    localparam int WB_WIDX_LSB     = 97;
    localparam int WB_IVALID_BIT   = 102;
    localparam int WB_BREAK_BIT    = 103;
    localparam int WB_VADDR_LSB    = 104;
    localparam int WB_LLEN_BIT     = 359;
    localparam int WB_LLVAL_BIT    = 360;

    localparam int WB_CSR_W        = 47;
    localparam int WB_CSR_WDATA_LSB = 0;
    localparam int WB_CSR_ADDR_LSB = 32;
    localparam int WB_CSR_WE_BIT   = 46;

    localparam int WB_EXCP_W       = 9;
    localparam int WB_EXCP_BIT     = 0;
    localparam int WB_EXCP_NUM_LSB = WB_EXCP_W - 8;
    localparam int WB_ERTN_BIT     = WB_EXCP_W - 1;

    typedef enum logic {WB_RUN, WB_FLUSH} wb_state_t;

endpackage

// File: rtl/wb_commit_trace.sv
// Difftest commit trace: registers the retiring instruction's architectural effects.
// Latency 1 cycle after commit; no backpressure, samples every cycle.
module wb_commit_trace (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic        excp_flush,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        rf_we,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    output logic        dt_valid,
    output logic [31:0] dt_pc,
    output logic [31:0] dt_inst,
    output logic        dt_wen,
    output logic [4:0]  dt_wdest,
    output logic [31:0] dt_wdata,
    output logic        dt_excp
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dt_valid <= 1'b0;
            dt_pc    <= '0;
            dt_inst  <= '0;
            dt_wen   <= 1'b0;
            dt_wdest <= '0;
            dt_wdata <= '0;
            dt_excp  <= 1'b0;
        end else begin
            dt_valid <= commit;
            dt_pc    <= commit ? pc   : '0;
            dt_inst  <= commit ? inst : '0;
            dt_wen   <= rf_we;
            dt_wdest <= rf_waddr;
            dt_wdata <= rf_wdata;
            dt_excp  <= excp_flush;
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: retires RF/CSR/LLbit writes, raises flushes, counts retires, sticky break halt.
// Latency 0 (outputs combinational on fire); left_ready low while halted or during the post-flush window.
// Optional DIFFTEST_COMMIT_EN adds a 1-cycle registered commit trace (wb_commit_trace).
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int CNT_W        = 64,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left_valid,
    output logic                 left_ready,
    output logic                 fire,
    input  logic [WB_CTRL_W-1:0] wb_ctrl_bus,
    input  logic [WB_CSR_W-1:0]  wb_csr_bus,
    input  logic [WB_EXCP_W-1:0] mem_excp_bus,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 csr_we,
    output logic [13:0]          csr_waddr,
    output logic [31:0]          csr_wdata,
    output logic                 llbit_we,
    output logic                 llbit_wval,
    output logic                 excp_flush,
    output logic                 ertn_flush,
    output logic [6:0]           excp_num,
    output logic [31:0]          excp_era,
    output logic [31:0]          excp_badv,
    output logic                 halt,
    output logic [CNT_W-1:0]     retire_cnt
`ifdef DIFFTEST_COMMIT_EN
    ,
    output logic                 dt_valid,
    output logic [31:0]          dt_pc,
    output logic [31:0]          dt_inst,
    output logic                 dt_wen,
    output logic [4:0]           dt_wdest,
    output logic [31:0]          dt_wdata,
    output logic                 dt_excp
`endif
);

    wb_state_t  state;
    logic [3:0] flush_cnt;

    logic        inst_valid, is_break, wreg_en, ll_en, ll_val;
    logic        excp, ertn, csr_we_in;
    logic        commit, good;
    logic [31:0] pc, inst, result, vaddr;
    logic [4:0]  wreg_index;

    assign result     = wb_ctrl_bus[WB_RESULT_LSB +: 32];
    assign pc         = wb_ctrl_bus[WB_PC_LSB +: 32];
    assign inst       = wb_ctrl_bus[WB_INST_LSB +: 32];
    assign wreg_en    = wb_ctrl_bus[WB_WEN_BIT];
    assign wreg_index = wb_ctrl_bus[WB_WIDX_LSB +: 5];
    assign inst_valid = wb_ctrl_bus[WB_IVALID_BIT];
    assign is_break   = wb_ctrl_bus[WB_BREAK_BIT];
    assign vaddr      = wb_ctrl_bus[WB_VADDR_LSB +: 32];
    assign ll_en      = wb_ctrl_bus[WB_LLEN_BIT];
    assign ll_val     = wb_ctrl_bus[WB_LLVAL_BIT];
    assign csr_we_in  = wb_csr_bus[WB_CSR_WE_BIT];
    assign excp       = mem_excp_bus[WB_EXCP_BIT];
    assign ertn       = mem_excp_bus[WB_ERTN_BIT];

    // Reset gates left_ready so every commit-derived output is forced low during reset.
    assign left_ready = (state == WB_RUN) & !halt & !reset;
    assign fire       = left_valid & left_ready;
    assign commit     = fire & inst_valid;
    assign good       = commit & !excp & !ertn;

    assign rf_we      = good & wreg_en;
    assign rf_waddr   = rf_we ? wreg_index : '0;
    assign rf_wdata   = rf_we ? result : '0;
    assign csr_we     = good & csr_we_in;
    assign csr_waddr  = csr_we ? wb_csr_bus[WB_CSR_ADDR_LSB +: 14] : '0;
    assign csr_wdata  = csr_we ? wb_csr_bus[WB_CSR_WDATA_LSB +: 32] : '0;
    assign llbit_we   = good & ll_en;
    assign llbit_wval = llbit_we & ll_val;

    assign excp_flush = commit & excp;
    assign ertn_flush = commit & ertn & !excp;
    assign excp_num   = excp_flush ? mem_excp_bus[WB_EXCP_NUM_LSB +: 7] : '0;
    assign excp_era   = commit ? pc : '0;
    assign excp_badv  = excp_flush ? vaddr : '0;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_ctrl_bus[WB_LLEN_BIT-1:WB_VADDR_LSB+32], inst};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WB_RUN;
            flush_cnt  <= '0;
            halt       <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (good)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (good && is_break)
                halt <= 1'b1;
            case (state)
                WB_RUN: begin
                    if (excp_flush || ertn_flush) begin
                        state     <= WB_FLUSH;
                        flush_cnt <= 4'(FLUSH_CYCLES);
                    end
                end
                WB_FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    // <=1 rather than ==1 so a stray zero count can never lock the stage.
                    if (flush_cnt <= 4'd1)
                        state <= WB_RUN;
                end
                default: state <= WB_RUN;
            endcase
        end
    end

`ifdef DIFFTEST_COMMIT_EN
    wb_commit_trace u_trace (
        .clk        (clk),
        .reset      (reset),
        .commit     (commit),
        .excp_flush (excp_flush),
        .pc         (pc),
        .inst       (inst),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .dt_valid   (dt_valid),
        .dt_pc      (dt_pc),
        .dt_inst    (dt_inst),
        .dt_wen     (dt_wen),
        .dt_wdest   (dt_wdest),
        .dt_wdata   (dt_wdata),
        .dt_excp    (dt_excp)
    );
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage (CNT_W=4 so counter wrap is reachable).
// Inputs change 1ns after posedge; combinational outputs sampled 3ns after posedge.
module tb_wb_commit_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         left_valid;
    logic         left_ready, fire;
    logic [360:0] wb_ctrl_bus;
    logic [46:0]  wb_csr_bus;
    logic [8:0]   mem_excp_bus;
    logic         rf_we, csr_we, llbit_we, llbit_wval, excp_flush, ertn_flush, halt;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata, csr_wdata, excp_era, excp_badv;
    logic [13:0]  csr_waddr;
    logic [6:0]   excp_num;
    logic [3:0]   retire_cnt;
`ifdef DIFFTEST_COMMIT_EN
    logic         dt_valid, dt_wen, dt_excp;
    logic [31:0]  dt_pc, dt_inst, dt_wdata;
    logic [4:0]   dt_wdest;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_commit_stage #(.CNT_W(4), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .left_valid(left_valid), .left_ready(left_ready), .fire(fire),
        .wb_ctrl_bus(wb_ctrl_bus), .wb_csr_bus(wb_csr_bus), .mem_excp_bus(mem_excp_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .llbit_we(llbit_we), .llbit_wval(llbit_wval),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .excp_num(excp_num),
        .excp_era(excp_era), .excp_badv(excp_badv), .halt(halt), .retire_cnt(retire_cnt)
`ifdef DIFFTEST_COMMIT_EN
        , .dt_valid(dt_valid), .dt_pc(dt_pc), .dt_inst(dt_inst), .dt_wen(dt_wen),
        .dt_wdest(dt_wdest), .dt_wdata(dt_wdata), .dt_excp(dt_excp)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [360:0] mk(input logic [31:0] pc, input logic [31:0] res,
                                        input logic wen, input logic [4:0] idx, input logic iv,
                                        input logic brk, input logic [31:0] va,
                                        input logic llen, input logic llval);
        logic [360:0] c;
        c = '0;
        c[31:0]    = res;
        c[63:32]   = pc;
        c[95:64]   = 32'h0280_0405;
        c[96]      = wen;
        c[101:97]  = idx;
        c[102]     = iv;
        c[103]     = brk;
        c[135:104] = va;
        c[359]     = llen;
        c[360]     = llval;
        return c;
    endfunction

    function automatic logic [8:0] mkx(input logic ertn, input logic [6:0] num, input logic ex);
        return {ertn, num, ex};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [360:0] c, input logic [46:0] s,
                         input logic [8:0] x);
        left_valid   = lv;
        wb_ctrl_bus  = c;
        wb_csr_bus   = s;
        mem_excp_bus = x;
        #2;
    endtask

    task automatic idle;
        drive(1'b0, '0, '0, '0);
    endtask

    logic [360:0] good_ld;
    logic [3:0]   exp_cnt;

    initial begin
        good_ld = mk(32'h1c00_0010, 32'hdead_beef, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, good_ld, '0, '0);
        chk("rst_ready", left_ready, 0);
        chk("rst_fire", fire, 0);
        chk("rst_rf_we", rf_we, 0);
        tick;
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_halt", halt, 0);
`ifdef DIFFTEST_COMMIT_EN
        chk("rst_dt_valid", dt_valid, 0);
`endif
        reset = 1'b0;

        // Load commit
        drive(1'b1, good_ld, '0, '0);
        chk("ld_ready", left_ready, 1);
        chk("ld_fire", fire, 1);
        chk("ld_rf_we", rf_we, 1);
        chk("ld_waddr", rf_waddr, 5);
        chk("ld_wdata", rf_wdata, 32'hdead_beef);
        chk("ld_excp_flush", excp_flush, 0);
        tick;
        chk("ld_cnt", retire_cnt, 1);

        // Exception commit
        drive(1'b1, mk(32'h1c00_0020, 32'h1234, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_abcd, 1'b0, 1'b0),
              '0, mkx(1'b0, 7'h08, 1'b1));
        chk("ex_flush", excp_flush, 1);
        chk("ex_rf_we", rf_we, 0);
        chk("ex_era", excp_era, 32'h1c00_0020);
        chk("ex_num", excp_num, 7'h08);
        chk("ex_badv", excp_badv, 32'h0000_abcd);
        tick;
        idle;
        chk("ex_ready_low", left_ready, 0);
        chk("ex_cnt_frozen", retire_cnt, 1);
        tick;
        chk("ex_ready_back", left_ready, 1);

        // ertn together with excp: exception wins
        drive(1'b1, good_ld, '0, mkx(1'b1, 7'h01, 1'b1));
        chk("ertnx_ertn", ertn_flush, 0);
        chk("ertnx_excp", excp_flush, 1);
        tick; idle; tick;

        // ertn alone, CSR write suppressed
        drive(1'b1, good_ld, {1'b1, 14'h0006, 32'h5555_aaaa}, mkx(1'b1, 7'h00, 1'b0));
        chk("ertn_flush", ertn_flush, 1);
        chk("ertn_excp", excp_flush, 0);
        chk("ertn_csr_we", csr_we, 0);
        tick;
        idle;
        chk("ertn_ready_low", left_ready, 0);
        tick;

        // Plain CSR write
        drive(1'b1, mk(32'h1c00_0030, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0),
              {1'b1, 14'h0180, 32'hcafe_f00d}, '0);
        chk("csr_we", csr_we, 1);
        chk("csr_addr", csr_waddr, 14'h0180);
        chk("csr_wdata", csr_wdata, 32'hcafe_f00d);
        tick;
        chk("csr_cnt", retire_cnt, 2);

        // Bubble: fire without inst_valid
        drive(1'b1, mk(32'h1c00_0040, 32'h99, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1), '0, '0);
        chk("bub_fire", fire, 1);
        chk("bub_rf_we", rf_we, 0);
        chk("bub_ll_we", llbit_we, 0);
        tick;
        chk("bub_cnt", retire_cnt, 2);
        idle;
        chk("idle_fire", fire, 0);

        // SC failure: LLbit cleared
        drive(1'b1, mk(32'h1c00_0050, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0), '0, '0);
        chk("sc_ll_we", llbit_we, 1);
        chk("sc_ll_val", llbit_wval, 0);
        tick;
        idle;
        chk("sc_cnt", retire_cnt, 3);
`ifdef DIFFTEST_COMMIT_EN
        chk("dt_valid_pulse", dt_valid, 1);
        chk("dt_pc", dt_pc, 32'h1c00_0050);
        chk("dt_wdest", dt_wdest, 4);
        tick;
        chk("dt_valid_drop", dt_valid, 0);
`endif

        // Counter wrap at CNT_W=4
        reset = 1'b1; idle; tick; reset = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, good_ld, '0, '0);
            tick;
            exp_cnt = exp_cnt + 4'd1;
            if (i == 14) chk("wrap_15", retire_cnt, 15);
            if (i == 15) chk("wrap_0", retire_cnt, 0);
        end
        chk("wrap_17", retire_cnt, 1);
        chk("wrap_model", retire_cnt, exp_cnt);

        // Break halts permanently
        drive(1'b1, mk(32'h1c00_0060, 32'h77, 1'b1, 5'd9, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0), '0, '0);
        chk("brk_rf_we", rf_we, 1);
        tick;
        chk("brk_halt", halt, 1);
        chk("brk_cnt", retire_cnt, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, good_ld, '0, '0);
            chk("halt_fire", fire, 0);
            chk("halt_ready", left_ready, 0);
            tick;
        end
        chk("halt_cnt_frozen", retire_cnt, 2);

        // Break with exception does not halt
        reset = 1'b1; idle; tick; reset = 1'b0;
        chk("rst_clears_halt", halt, 0);
        drive(1'b1, mk(32'h1c00_0070, 32'h0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0),
              '0, mkx(1'b0, 7'h0c, 1'b1));
        tick;
        idle;
        chk("brkx_no_halt", halt, 0);
        chk("brkx_in_flush", left_ready, 0);
        // Reset while in FLUSH
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #2;
        chk("rstflush_ready", left_ready, 1);
        chk("rstflush_cnt", retire_cnt, 0);
        chk("rstflush_halt", halt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
